// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM channel blocks: register map, CTRL bit
// positions, ramp sequencer states and the default datapath width.
package pwm_pkg;

    // Default width of period / compare datapaths
    localparam int PWM_WIDTH_DEFAULT = 16;

    // Host register map (2-bit word address)
    localparam logic [1:0] PWM_A_PERIOD = 2'd0;
    localparam logic [1:0] PWM_A_TARGET = 2'd1;
    localparam logic [1:0] PWM_A_STEP   = 2'd2;
    localparam logic [1:0] PWM_A_CTRL   = 2'd3;

    // CTRL register bit positions
    localparam int PWM_CTRL_GO    = 0;
    localparam int PWM_CTRL_ABORT = 1;

    // Ramp sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RAMP = 2'd2,
        HOLD = 2'd3
    } pwm_ramp_state_t;

endpackage

// File: rtl/pwm_period_timer.sv
// Period timer for one PWM channel. Counts 0..max_count and wraps, flags the
// last cycle of each period (boundary) and emits a registered period_start
// pulse that is high on the first cycle of every period. With max_count == 0
// every cycle is a boundary, so period_start stays high continuously.
module pwm_period_timer
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] max_count,
    output logic             boundary,
    output logic             period_start
);

    logic [WIDTH-1:0] pcnt_reg;
    logic             period_start_reg;

    // Boundary is the cycle where the count sits on the active period value
    assign boundary     = (pcnt_reg == max_count);
    assign period_start = period_start_reg;

    // Free-running period counter and first-cycle-of-period flag
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_reg         <= '0;
            period_start_reg <= 1'b0;
        end else begin
            if (boundary) begin
                pcnt_reg <= '0;
            end else begin
                pcnt_reg <= pcnt_reg + 1'b1;
            end
            period_start_reg <= boundary;
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Configuration and sequencing controller for one PWM channel.
// Host writes land in shadow registers immediately; the active max_count and
// cmp_val seen by the PWM counter only change on a period boundary, so the
// output never sees a torn period. On GO the compare value ramps toward the
// target by a fixed step per period, then holds. ABORT ramps down to 0 and
// returns to IDLE.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int WIDTH  = PWM_WIDTH_DEFAULT,
    parameter int STEP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_addr,
    input  logic [WIDTH-1:0] cfg_wdata,
    output logic [WIDTH-1:0] max_count,
    output logic [WIDTH-1:0] cmp_val,
    output logic             period_start,
    output logic             busy
);

    pwm_ramp_state_t  state_reg;
    pwm_ramp_state_t  state_next;

    logic [WIDTH-1:0]  sh_period_reg;
    logic [WIDTH-1:0]  sh_target_reg;
    logic [STEP_W-1:0] sh_step_reg;
    logic              abort_reg;

    logic [WIDTH-1:0]  max_count_reg;
    logic [WIDTH-1:0]  max_count_next;
    logic [WIDTH-1:0]  cmp_val_reg;
    logic [WIDTH-1:0]  cmp_val_next;
    logic              cfg_ready_reg;

    logic              boundary;
    logic              wr_en;
    logic              ctrl_wr;
    logic              go_cmd;
    logic              abort_cmd;

    // Ramp arithmetic is one bit wider than the datapath so neither the
    // up-sum nor the down-difference can wrap before clamping.
    logic [WIDTH:0]    cmp_ext;
    logic [WIDTH:0]    tgt_ext;
    logic [WIDTH:0]    step_ext;
    logic [WIDTH:0]    up_sum;
    logic [WIDTH:0]    dn_diff;
    logic [WIDTH-1:0]  ramp_val;

    // Handshake decode. GO and ABORT together resolve to ABORT; ABORT only
    // means something once a sequence has been started.
    assign wr_en     = cfg_valid & cfg_ready_reg;
    assign ctrl_wr   = wr_en && (cfg_addr == PWM_A_CTRL);
    assign go_cmd    = ctrl_wr && cfg_wdata[PWM_CTRL_GO] && !cfg_wdata[PWM_CTRL_ABORT];
    assign abort_cmd = ctrl_wr && cfg_wdata[PWM_CTRL_ABORT] && (state_reg != IDLE);

    assign cfg_ready = cfg_ready_reg;
    assign max_count = max_count_reg;
    assign cmp_val   = cmp_val_reg;
    assign busy      = (state_reg == ARM) || (state_reg == RAMP);

    pwm_period_timer #(
        .WIDTH(WIDTH)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .max_count    (max_count_reg),
        .boundary     (boundary),
        .period_start (period_start)
    );

    assign cmp_ext  = {1'b0, cmp_val_reg};
    assign tgt_ext  = {1'b0, sh_target_reg};
    assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, sh_step_reg};
    assign up_sum   = cmp_ext + step_ext;
    assign dn_diff  = cmp_ext - step_ext;

    // Next compare value: one step toward the target, clamped to it.
    // A zero step means jump straight to the target.
    always_comb begin
        ramp_val = sh_target_reg;
        if (sh_step_reg != '0) begin
            if (cmp_val_reg < sh_target_reg) begin
                if (up_sum < tgt_ext) begin
                    ramp_val = up_sum[WIDTH-1:0];
                end
            end else if (cmp_val_reg > sh_target_reg) begin
                // dn_diff[WIDTH] set means the subtraction went below zero
                if (!dn_diff[WIDTH] && (dn_diff > tgt_ext)) begin
                    ramp_val = dn_diff[WIDTH-1:0];
                end
            end
        end
    end

    // Shadow registers and the pending-abort flag. A write on a boundary
    // cycle updates the shadow, but the commit in that same cycle still sees
    // the old value, so it applies one period later.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_period_reg <= '0;
            sh_target_reg <= '0;
            sh_step_reg   <= '0;
            abort_reg     <= 1'b0;
        end else begin
            if (state_reg == IDLE) begin
                abort_reg <= 1'b0;
            end
            if (wr_en) begin
                case (cfg_addr)
                    PWM_A_PERIOD: sh_period_reg <= cfg_wdata;
                    PWM_A_TARGET: begin
                        // A fresh target from the host supersedes a pending abort
                        sh_target_reg <= cfg_wdata;
                        abort_reg     <= 1'b0;
                    end
                    PWM_A_STEP:   sh_step_reg <= cfg_wdata[STEP_W-1:0];
                    default: begin
                        if (abort_cmd) begin
                            sh_target_reg <= '0;
                            abort_reg     <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Sequencer next-state and boundary commit of the active registers
    always_comb begin
        state_next     = state_reg;
        max_count_next = max_count_reg;
        cmp_val_next   = cmp_val_reg;
        case (state_reg)
            IDLE: begin
                if (go_cmd) begin
                    state_next = ARM;
                end
            end
            ARM: begin
                // The arming boundary only loads the period; no compare step
                if (boundary) begin
                    max_count_next = sh_period_reg;
                    state_next     = RAMP;
                end
            end
            RAMP, HOLD: begin
                // HOLD re-enters the ramp on the same boundary that detects
                // a changed target, so the first step is not delayed.
                if (boundary) begin
                    max_count_next = sh_period_reg;
                    cmp_val_next   = ramp_val;
                    if (ramp_val == sh_target_reg) begin
                        state_next = abort_reg ? IDLE : HOLD;
                    end else begin
                        state_next = RAMP;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and active output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            max_count_reg <= '1;
            cmp_val_reg   <= '0;
            cfg_ready_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            max_count_reg <= max_count_next;
            cmp_val_reg   <= cmp_val_next;
            cfg_ready_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl. Expected compare values are queued
// when stimulus is written and popped as the DUT updates cmp_val.
module tb_pwm_ramp_ctrl;
    import pwm_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_valid = 1'b0;
    logic [1:0]   cfg_addr = 2'd0;
    logic [W-1:0] cfg_wdata = '0;
    logic         cfg_ready;
    logic [W-1:0] max_count;
    logic [W-1:0] cmp_val;
    logic         period_start;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [W-1:0] exp_q[$];

    pwm_ramp_ctrl #(.WIDTH(W), .STEP_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .max_count    (max_count),
        .cmp_val      (cmp_val),
        .period_start (period_start),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [W-1:0] d);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_valid = 1'b0;
        $display("write addr=%0d data=%h at cycle %0d", a, d, cyc);
    endtask

    task automatic wait_cmp_change(input int budget, output logic [W-1:0] v,
                                   output int c, output bit to);
        logic [W-1:0] prev;
        int i;
        prev = cmp_val;
        to = 1'b1;
        v = cmp_val;
        c = cyc;
        i = 0;
        while (to && i < budget) begin
            tick();
            if (cmp_val !== prev) begin
                to = 1'b0;
                v = cmp_val;
                c = cyc;
            end
            i++;
        end
        $display("cmp_val now %h at cycle %0d (timeout=%0d)", v, c, to);
    endtask

    task automatic wait_pstart(input int budget, output int c, output bit to);
        int i;
        to = 1'b1;
        c = cyc;
        i = 0;
        while (to && i < budget) begin
            tick();
            if (period_start === 1'b1) begin
                to = 1'b0;
                c = cyc;
            end
            i++;
        end
        $display("period_start at cycle %0d (timeout=%0d)", c, to);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++; if (max_count !== 16'hFFFF) begin bad++; $display("FAIL rst_max_count: got %h expected %h", max_count, 16'hFFFF); end
        total++; if (cmp_val !== 16'h0000) begin bad++; $display("FAIL rst_cmp_val: got %h expected %h", cmp_val, 16'h0000); end
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL rst_cfg_ready: got %b expected 0", cfg_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
        total++; if (period_start !== 1'b0) begin bad++; $display("FAIL rst_period_start: got %b expected 0", period_start); end
        rst = 1'b0;
        tick();
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL post_rst_cfg_ready: got %b expected 1", cfg_ready); end
        $display("reset released at cycle %0d", cyc);
    endtask

    task automatic test_up_ramp();
        logic [W-1:0] v, e;
        int c, prev_c, k;
        bit to;
        do_write(PWM_A_PERIOD, 16'd9);
        do_write(PWM_A_TARGET, 16'd25);
        do_write(PWM_A_STEP, 16'd10);
        do_write(PWM_A_CTRL, 16'h0001);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL go_busy: got %b expected 1", busy); end
        exp_q.push_back(16'd10);
        exp_q.push_back(16'd20);
        exp_q.push_back(16'd25);
        prev_c = 0;
        k = 0;
        while (exp_q.size() > 0) begin
            wait_cmp_change(70000, v, c, to);
            e = exp_q.pop_front();
            total++; if (to || v !== e) begin bad++; $display("FAIL up_ramp_val: got %h expected %h timeout=%0d", v, e, to); end
            total++; if (period_start !== 1'b1) begin bad++; $display("FAIL up_ramp_pstart: got %b expected 1", period_start); end
            if (k > 0) begin
                total++; if (c - prev_c != 10) begin bad++; $display("FAIL up_ramp_interval: got %0d expected 10", c - prev_c); end
            end
            total++; if (busy !== (e != 16'd25)) begin bad++; $display("FAIL up_ramp_busy: got %b expected %b", busy, (e != 16'd25)); end
            prev_c = c;
            k++;
            if (to) exp_q.delete();
        end
        total++; if (max_count !== 16'd9) begin bad++; $display("FAIL up_ramp_max_count: got %h expected %h", max_count, 16'd9); end
    endtask

    task automatic test_mid_period_write();
        logic [W-1:0] v, e;
        int c0, c, prev_c, k;
        bit to;
        wait_pstart(50, c0, to);
        total++; if (to) begin bad++; $display("FAIL mid_pstart: got timeout expected pulse"); end
        repeat (3) tick();
        do_write(PWM_A_TARGET, 16'd5);
        total++; if (cmp_val !== 16'd25) begin bad++; $display("FAIL mid_hold_val: got %h expected %h", cmp_val, 16'd25); end
        exp_q.push_back(16'd15);
        exp_q.push_back(16'd5);
        prev_c = c0;
        k = 0;
        while (exp_q.size() > 0) begin
            wait_cmp_change(40, v, c, to);
            e = exp_q.pop_front();
            total++; if (to || v !== e) begin bad++; $display("FAIL mid_val: got %h expected %h timeout=%0d", v, e, to); end
            total++; if (c - prev_c != 10) begin bad++; $display("FAIL mid_interval: got %0d expected 10", c - prev_c); end
            total++; if (period_start !== 1'b1) begin bad++; $display("FAIL mid_pstart_at_update: got %b expected 1", period_start); end
            prev_c = c;
            k++;
            if (to) exp_q.delete();
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_hold: got %b expected 0", busy); end
    endtask

    task automatic test_boundary_collision();
        int c0, c2, c3;
        bit to;
        wait_pstart(50, c0, to);
        repeat (9) tick();
        do_write(PWM_A_PERIOD, 16'd19);
        total++; if (period_start !== 1'b1 || cyc - c0 != 10) begin bad++; $display("FAIL coll_first_boundary: got pstart=%b after %0d expected 1 after 10", period_start, cyc - c0); end
        total++; if (max_count !== 16'd9) begin bad++; $display("FAIL coll_old_period: got %h expected %h", max_count, 16'd9); end
        wait_pstart(50, c2, to);
        total++; if (to || c2 - c0 != 20) begin bad++; $display("FAIL coll_next_period: got %0d expected 20", c2 - c0); end
        total++; if (max_count !== 16'd19) begin bad++; $display("FAIL coll_new_period: got %h expected %h", max_count, 16'd19); end
        wait_pstart(50, c3, to);
        total++; if (to || c3 - c2 != 20) begin bad++; $display("FAIL coll_long_period: got %0d expected 20", c3 - c2); end
    endtask

    task automatic test_abort();
        logic [W-1:0] v, e;
        int c;
        bit to;
        do_write(PWM_A_PERIOD, 16'd9);
        do_write(PWM_A_TARGET, 16'd0);
        exp_q.push_back(16'd0);
        do_write(PWM_A_TARGET, 16'd0);
        while (exp_q.size() > 0) begin
            wait_cmp_change(60, v, c, to);
            e = exp_q.pop_front();
            total++; if (to || v !== e) begin bad++; $display("FAIL abort_setup_val: got %h expected %h", v, e); end
        end
        do_write(PWM_A_TARGET, 16'd40);
        exp_q.push_back(16'd10);
        exp_q.push_back(16'd20);
        while (exp_q.size() > 0) begin
            wait_cmp_change(40, v, c, to);
            e = exp_q.pop_front();
            total++; if (to || v !== e) begin bad++; $display("FAIL abort_rampup_val: got %h expected %h", v, e); end
            if (to) exp_q.delete();
        end
        do_write(PWM_A_CTRL, 16'h0003);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_after_cmd: got %b expected 1", busy); end
        exp_q.push_back(16'd10);
        exp_q.push_back(16'd0);
        while (exp_q.size() > 0) begin
            wait_cmp_change(40, v, c, to);
            e = exp_q.pop_front();
            total++; if (to || v !== e) begin bad++; $display("FAIL abort_down_val: got %h expected %h timeout=%0d", v, e, to); end
            total++; if (busy !== (e != 16'd0)) begin bad++; $display("FAIL abort_down_busy: got %b expected %b", busy, (e != 16'd0)); end
            if (to) exp_q.delete();
        end
        repeat (25) tick();
        total++; if (cmp_val !== 16'd0 || busy !== 1'b0) begin bad++; $display("FAIL abort_idle: got cmp=%h busy=%b expected 0000 0", cmp_val, busy); end
        do_write(PWM_A_CTRL, 16'h0003);
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_go_abort: got busy=%b expected 0", busy); end
    endtask

    task automatic test_clamp();
        logic [W-1:0] v, e;
        int c;
        bit to;
        // ABORT in IDLE must not clear the target written just before it
        do_write(PWM_A_TARGET, 16'd50);
        do_write(PWM_A_CTRL, 16'h0002);
        do_write(PWM_A_STEP, 16'd0);
        do_write(PWM_A_CTRL, 16'h0001);
        exp_q.push_back(16'd50);
        do_write(PWM_A_TARGET, 16'd50);
        wait_cmp_change(40, v, c, to);
        e = exp_q.pop_front();
        total++; if (to || v !== e) begin bad++; $display("FAIL idle_abort_ignored: got %h expected %h", v, e); end
        do_write(PWM_A_TARGET, 16'hFFF0);
        exp_q.push_back(16'hFFF0);
        wait_cmp_change(40, v, c, to);
        e = exp_q.pop_front();
        total++; if (to || v !== e) begin bad++; $display("FAIL step0_jump_high: got %h expected %h", v, e); end
        do_write(PWM_A_STEP, 16'h00FF);
        do_write(PWM_A_TARGET, 16'hFFFF);
        exp_q.push_back(16'hFFFF);
        wait_cmp_change(40, v, c, to);
        e = exp_q.pop_front();
        total++; if (to || v !== e) begin bad++; $display("FAIL clamp_top: got %h expected %h", v, e); end
        total++; if (max_count !== 16'd9) begin bad++; $display("FAIL no_cmp_clamp_max: got %h expected %h", max_count, 16'd9); end
        do_write(PWM_A_STEP, 16'd0);
        do_write(PWM_A_TARGET, 16'd100);
        exp_q.push_back(16'd100);
        wait_cmp_change(40, v, c, to);
        e = exp_q.pop_front();
        total++; if (to || v !== e) begin bad++; $display("FAIL step0_jump: got %h expected %h", v, e); end
        do_write(PWM_A_STEP, 16'h00FF);
        do_write(PWM_A_TARGET, 16'd0);
        exp_q.push_back(16'd0);
        wait_cmp_change(40, v, c, to);
        e = exp_q.pop_front();
        total++; if (to || v !== e) begin bad++; $display("FAIL clamp_bottom: got %h expected %h", v, e); end
    endtask

    task automatic test_zero_period();
        int c;
        bit to;
        do_write(PWM_A_PERIOD, 16'd0);
        wait_pstart(40, c, to);
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (period_start !== 1'b1 || max_count !== 16'd0) begin bad++; $display("FAIL zero_period: got pstart=%b max=%h expected 1 0000", period_start, max_count); end
        end
    endtask

    task automatic test_reset_mid_ramp();
        logic [W-1:0] v;
        int c;
        bit to;
        do_write(PWM_A_STEP, 16'd1);
        do_write(PWM_A_PERIOD, 16'd9);
        do_write(PWM_A_TARGET, 16'd1000);
        wait_cmp_change(40, v, c, to);
        total++; if (to || busy !== 1'b1) begin bad++; $display("FAIL pre_rst_busy: got %b expected 1 (cmp %h)", busy, v); end
        rst = 1'b1;
        tick();
        total++; if (max_count !== 16'hFFFF || cmp_val !== 16'd0 || busy !== 1'b0 || cfg_ready !== 1'b0 || period_start !== 1'b0) begin
            bad++; $display("FAIL mid_rst_outputs: got max=%h cmp=%h busy=%b rdy=%b ps=%b expected ffff 0000 0 0 0", max_count, cmp_val, busy, cfg_ready, period_start);
        end
        rst = 1'b0;
        tick();
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready: got %b expected 1", cfg_ready); end
        repeat (20) tick();
        total++; if (cmp_val !== 16'd0 || busy !== 1'b0) begin bad++; $display("FAIL ramp_lost: got cmp=%h busy=%b expected 0000 0", cmp_val, busy); end
    endtask

    initial begin
        test_reset();
        test_up_ramp();
        test_mid_period_write();
        test_boundary_collision();
        test_abort();
        test_clamp();
        test_zero_period();
        test_reset_mid_ramp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
